// File: rtl/core_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
//   PC_W / INSTR_W     : word-address and instruction widths
//   DEFAULT_RESET_PC   : PC value loaded on reset
//   DEFAULT_DEPTH      : prefetch buffer entries
//   fetch_entry_t      : {pc, instr} buffer payload
package core_fetch_pkg;

    localparam int unsigned PC_W          = 15;
    localparam int unsigned INSTR_W       = 16;
    localparam int unsigned DEFAULT_DEPTH = 2;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 15'h0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/core_fetch_unit_fifo.sv
// Prefetch buffer: small circular FIFO of {pc, instr} entries.
//   i_clk, i_rst     : clock, async active-high reset
//   i_push, i_data   : write entry at tail (ignored when full)
//   i_pop            : retire head entry (ignored when empty)
//   i_flush          : empty the buffer; overrides push and pop
//   o_full, o_empty  : occupancy flags from the registered count
//   o_head           : head entry contents
module fetch_fifo
    import core_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_head];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage, pointers and count; storage is cleared on reset so the head is defined.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_do_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/core_fetch_unit.sv
// Instruction fetch unit: PC register, redirect handling and a prefetch buffer.
//   i_clk, i_rst                 : clock, async active-high reset
//   o_iAddr                      : current PC, drives instruction memory address
//   i_iIsBusy                    : memory serving data; no fetch this cycle
//   i_memData                    : instruction word for o_iAddr when not busy
//   i_redirect, i_redirectAddr   : flush buffer and restart at target
//   i_stall                      : decode not accepting the head this cycle
//   o_instr, o_instrPc           : head instruction and its word address
//   o_instrValid                 : head holds a valid instruction
module core_fetch_unit
    import core_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = DEFAULT_DEPTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic [PC_W-1:0]    o_iAddr,
    input  logic               i_iIsBusy,
    input  logic [INSTR_W-1:0] i_memData,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirectAddr,
    input  logic               i_stall,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instrPc,
    output logic               o_instrValid
);

    logic [PC_W-1:0] r_pc;
    logic            w_full;
    logic            w_empty;
    logic            w_fetch;
    logic            w_pop;
    fetch_entry_t    w_push_data;
    fetch_entry_t    w_head;

    // Fullness is the registered count, so a same-cycle pop never frees a slot for a push.
    assign w_fetch     = !i_iIsBusy && !w_full && !i_redirect;
    assign w_pop       = o_instrValid && !i_stall && !i_redirect;
    assign w_push_data = '{pc: r_pc, instr: i_memData};

    // PC advances only on a completed fetch; redirect wins over everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_redirectAddr;
        end else if (w_fetch) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_data  (w_push_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign o_iAddr      = r_pc;
    assign o_instrValid = !w_empty;
    assign o_instr      = w_head.instr;
    assign o_instrPc    = w_head.pc;

endmodule

// File: tb/tb_core_fetch_unit.sv
module tb_core_fetch_unit;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        redirect;
    logic [14:0] redirect_addr;
    logic        stall;
    logic [14:0] iaddr;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [14:0] instr_pc;
    logic        instr_valid;

    logic [14:0] w_iaddr;
    logic [15:0] w_mem_data;
    logic [15:0] w_instr;
    logic [14:0] w_instr_pc;
    logic        w_instr_valid;

    int n_checks;
    int n_fail;

    // Memory model: data = address + 0xA000
    assign mem_data   = 16'({1'b0, iaddr}) + 16'hA000;
    assign w_mem_data = 16'({1'b0, w_iaddr}) + 16'hA000;

    core_fetch_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_iAddr        (iaddr),
        .i_iIsBusy      (busy),
        .i_memData      (mem_data),
        .i_redirect     (redirect),
        .i_redirectAddr (redirect_addr),
        .i_stall        (stall),
        .o_instr        (instr),
        .o_instrPc      (instr_pc),
        .o_instrValid   (instr_valid)
    );

    // Free-running instance starting near the top of the address space
    core_fetch_unit #(
        .RESET_PC (15'h7FFE)
    ) dut_wrap (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_iAddr        (w_iaddr),
        .i_iIsBusy      (1'b0),
        .i_memData      (w_mem_data),
        .i_redirect     (1'b0),
        .i_redirectAddr (15'h0000),
        .i_stall        (1'b0),
        .o_instr        (w_instr),
        .o_instrPc      (w_instr_pc),
        .o_instrValid   (w_instr_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        busy          = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        stall         = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [14:0] pc,
                              input logic [15:0] ins);
        check({tag, "_valid"}, 32'(instr_valid), 32'(v));
        check({tag, "_pc"}, 32'(instr_pc), 32'(pc));
        check({tag, "_instr"}, 32'(instr), 32'(ins));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset state, then free-running fetch
        do_reset();
        check_head("rst", 1'b0, 15'h0000, 16'h0000);
        check("rst_iaddr", 32'(iaddr), 32'h0);
        check("wrap_rst_iaddr", 32'(w_iaddr), 32'h7FFE);
        check("wrap_rst_valid", 32'(w_instr_valid), 32'h0);
        step();
        check_head("run0", 1'b1, 15'h0000, 16'hA000);
        check("wrap0_pc", 32'(w_instr_pc), 32'h7FFE);
        check("wrap0_instr", 32'(w_instr), 32'h1FFE);
        step();
        check_head("run1", 1'b1, 15'h0001, 16'hA001);
        check("wrap1_pc", 32'(w_instr_pc), 32'h7FFF);
        check("wrap1_instr", 32'(w_instr), 32'h1FFF);
        step();
        check_head("run2", 1'b1, 15'h0002, 16'hA002);
        check("wrap2_pc", 32'(w_instr_pc), 32'h0000);
        check("wrap2_instr", 32'(w_instr), 32'hA000);
        check("run_iaddr", 32'(iaddr), 32'h3);

        // Stall with full buffer, then drain in order
        do_reset();
        step();
        check_head("st_first", 1'b1, 15'h0000, 16'hA000);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_head($sformatf("st_hold%0d", i), 1'b1, 15'h0000, 16'hA000);
            check($sformatf("st_iaddr%0d", i), 32'(iaddr), 32'h2);
        end
        stall = 1'b0;
        step();
        check_head("st_rel0", 1'b1, 15'h0001, 16'hA001);
        check("st_rel0_iaddr", 32'(iaddr), 32'h2);
        step();
        check_head("st_rel1", 1'b1, 15'h0002, 16'hA002);
        step();
        check_head("st_rel2", 1'b1, 15'h0003, 16'hA003);

        // Busy alternating 1,0
        do_reset();
        busy = 1'b1;
        step();
        check("bz0_valid", 32'(instr_valid), 32'h0);
        check("bz0_iaddr", 32'(iaddr), 32'h0);
        busy = 1'b0;
        step();
        check_head("bz1", 1'b1, 15'h0000, 16'hA000);
        busy = 1'b1;
        step();
        check("bz2_valid", 32'(instr_valid), 32'h0);
        check("bz2_iaddr", 32'(iaddr), 32'h1);
        busy = 1'b0;
        step();
        check_head("bz3", 1'b1, 15'h0001, 16'hA001);
        busy = 1'b1;
        step();
        check("bz4_valid", 32'(instr_valid), 32'h0);
        busy = 1'b0;
        step();
        check_head("bz5", 1'b1, 15'h0002, 16'hA002);

        // Redirect while full and stalled
        do_reset();
        stall = 1'b1;
        step();
        step();
        check("rd_full_iaddr", 32'(iaddr), 32'h2);
        redirect      = 1'b1;
        redirect_addr = 15'h1234;
        step();
        check("rd_valid", 32'(instr_valid), 32'h0);
        check("rd_iaddr", 32'(iaddr), 32'h1234);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        check_head("rd_first", 1'b1, 15'h1234, 16'hB234);

        // Back-to-back redirects: last one wins
        redirect      = 1'b1;
        redirect_addr = 15'h0100;
        step();
        redirect_addr = 15'h0200;
        step();
        check("rr_valid", 32'(instr_valid), 32'h0);
        check("rr_iaddr", 32'(iaddr), 32'h200);
        redirect = 1'b0;
        step();
        check_head("rr_first", 1'b1, 15'h0200, 16'hA200);

        // Async reset pulse between edges with two entries buffered
        do_reset();
        stall = 1'b1;
        step();
        step();
        check("ar_full_iaddr", 32'(iaddr), 32'h2);
        #2 rst = 1'b1;
        #1;
        check_head("ar_mid", 1'b0, 15'h0000, 16'h0000);
        check("ar_mid_iaddr", 32'(iaddr), 32'h0);
        #1 rst = 1'b0;
        stall = 1'b0;
        step();
        check_head("ar_resume0", 1'b1, 15'h0000, 16'hA000);
        step();
        check_head("ar_resume1", 1'b1, 15'h0001, 16'hA001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_fetch_unit.md
CORE_FETCH_UNIT -- requirements
Module: core_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 15'h0000, word address loaded into PC on reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries (fixed at 2; other values unsupported).
REQ-003 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 o_iAddr  out  15  word address of instruction fetch, feeds memory controller instruction address.
REQ-006 i_iIsBusy  in  1  memory controller serving data this cycle; instruction read not performed.
REQ-007 i_memData  in  16  raw unified memory data bus; valid for o_iAddr in any cycle with i_iIsBusy=0.
REQ-008 i_redirect  in  1  branch/jump taken; flush and refetch.
REQ-009 i_redirectAddr  in  15  target word address for i_redirect.
REQ-010 i_stall  in  1  decode cannot accept an instruction this cycle.
REQ-011 o_instr  out  16  instruction at buffer head.
REQ-012 o_instrPc  out  15  word address of o_instr.
REQ-013 o_instrValid  out  1  buffer head holds a valid instruction.

Function
REQ-014 PC register SHALL drive o_iAddr combinationally every cycle.
REQ-015 Fetch SHALL complete on an edge where i_iIsBusy=0, buffer not full, i_redirect=0: {PC, i_memData} pushed at tail, PC <= PC+1.
REQ-016 Buffer full SHALL mean count==DEPTH evaluated before this cycle's pop; no push and no PC advance when full, even if a pop occurs same cycle.
REQ-017 PC increment SHALL wrap 15'h7FFF -> 15'h0000 with no flag.
REQ-018 o_instrValid SHALL equal (count!=0); o_instr/o_instrPc SHALL be head entry contents, held stable while o_instrValid=1 and i_stall=1.
REQ-019 Pop SHALL occur on an edge with o_instrValid=1 and i_stall=0; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-020 i_iIsBusy=1 SHALL suppress push and PC advance; i_memData ignored that cycle.
REQ-021 i_redirect=1 SHALL, on that edge, empty the buffer (count<=0), load PC <= i_redirectAddr, and discard any same-cycle fetch and pop; o_instrValid=0 the next cycle.
REQ-022 Redirect SHALL take priority over stall, busy, push and pop; consecutive redirects each take effect, last one wins.
REQ-023 First instruction after redirect SHALL appear at o_instrValid no earlier than 1 cycle after the redirect edge, at the first non-busy cycle.
REQ-024 Count SHALL never exceed DEPTH nor underflow below 0.
REQ-025 No combinational path SHALL exist from i_memData to any output.

Reset
REQ-026 On i_rst=1, asynchronously: PC=RESET_PC, count=0, head/tail pointers=0, o_instrValid=0, o_instr=16'h0000, o_instrPc=15'h0000.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries; first fetch after deassertion SHALL use RESET_PC.
REQ-028 Buffer storage data SHALL be reset to zero so outputs are defined.

Structure
REQ-029 Shared package core_fetch_pkg SHALL hold PC width (15), instruction width (16), default RESET_PC and DEPTH constants, and the {pc, instr} entry typedef.
REQ-030 Buffer SHALL be one sub-module fetch_fifo (push/pop/flush, full/empty, head outputs); PC/redirect logic in core_fetch_unit top.

Verification
REQ-031 Reset, i_iIsBusy=0, memory returns addr+16'hA000, i_stall=0 -> o_instrValid=1 from 2nd edge, o_instrPc 0,1,2,... with o_instr 16'hA000,16'hA001,...
REQ-032 i_stall=1 held 5 cycles after first fetch -> count reaches 2, o_iAddr frozen at 15'h0002, o_instr stays 16'hA000; release -> 16'hA001, 16'hA002 in order, no gaps or duplicates.
REQ-033 i_iIsBusy alternating 1,0 -> one push per non-busy cycle; o_instrPc increments by 1 with no skipped or repeated addresses.
REQ-034 Buffer full plus i_redirect=1, i_redirectAddr=15'h1234, i_stall=1 same cycle -> next cycle o_instrValid=0, o_iAddr=15'h1234; then o_instrPc=15'h1234.
REQ-035 RESET_PC=15'h7FFE, free-running -> o_instrPc 15'h7FFE, 15'h7FFF, 15'h0000.
REQ-036 i_rst pulsed asynchronously between edges with 2 entries buffered -> o_instrValid=0 immediately, o_iAddr=RESET_PC, resumes at RESET_PC after deassertion.
